// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: FSM state encoding, octant bit map and default screen size.
package rast_pkg;
    localparam int RAST_XW   = 10;
    localparam int RAST_YW   = 9;

    localparam int OCT_STEEP = 0;
    localparam int OCT_NEG_X = 1;
    localparam int OCT_NEG_Y = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } state_e;
endpackage

// File: rtl/octant_swapback.sv
// Maps a normalised first-octant offset (u major, v minor) back to screen coordinates.
// Latency: combinational; backpressure: none, follows its registered inputs.
module octant_swapback
    import rast_pkg::*;
#(
    parameter int XW = RAST_XW,
    parameter int YW = RAST_YW,
    parameter int CW = (XW > YW) ? XW : YW
) (
    input  logic [CW-1:0] u,
    input  logic [CW-1:0] v,
    input  logic [2:0]    octant,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y
);
    logic [CW-1:0] off_x;
    logic [CW-1:0] off_y;

    always_comb begin
        off_x = octant[OCT_STEEP] ? v : u;
        off_y = octant[OCT_STEEP] ? u : v;
        // Sums wrap to the coordinate width; legal endpoints never overflow.
        pix_x = XW'(octant[OCT_NEG_X] ? (CW'(x0) - off_x) : (CW'(x0) + off_x));
        pix_y = YW'(octant[OCT_NEG_Y] ? (CW'(y0) - off_y) : (CW'(y0) + off_y));
    end
endmodule

// File: rtl/line_octant_stepper.sv
// Bresenham line stepper: one line per start handshake, one pixel per pix handshake.
// Latency: first pixel 2 cycles after accept; backpressure: pix_ready low freezes all state.
module line_octant_stepper
    import rast_pkg::*;
#(
    parameter int XW = RAST_XW,
    parameter int YW = RAST_YW,
    parameter int CW = (XW > YW) ? XW : YW,
    parameter int EW = CW + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_last,
    output logic [2:0]    octant,
    output logic          busy
);
    state_e               state_q, state_d;
    logic [XW-1:0]        x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0]        y0_q, y0_d, y1_q, y1_d;
    logic [2:0]           oct_q, oct_d;
    logic [CW-1:0]        u_q, u_d, v_q, v_d, count_q, count_d;
    logic signed [EW-1:0] err_q, err_d, inc_a_q, inc_a_d, inc_b_q, inc_b_d;

    logic signed [XW:0]   dx;
    logic signed [YW:0]   dy;
    logic [CW-1:0]        adx, ady, major, minor;
    logic                 steep;
    logic signed [EW-1:0] major_s, minor_s;
    logic                 pix_hs;

    always_comb begin
        dx      = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
        dy      = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
        adx     = CW'($unsigned(dx[XW] ? -dx : dx));
        ady     = CW'($unsigned(dy[YW] ? -dy : dy));
        steep   = ady > adx;
        major   = steep ? ady : adx;
        minor   = steep ? adx : ady;
        major_s = $signed(EW'(major));
        minor_s = $signed(EW'(minor));
        pix_hs  = (state_q == STEP) && pix_ready;
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        oct_d   = oct_q;
        u_d     = u_q;
        v_d     = v_q;
        count_d = count_q;
        err_d   = err_q;
        inc_a_d = inc_a_q;
        inc_b_d = inc_b_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                oct_d            = '0;
                oct_d[OCT_STEEP] = steep;
                oct_d[OCT_NEG_X] = dx[XW];
                oct_d[OCT_NEG_Y] = dy[YW];
                u_d              = '0;
                v_d              = '0;
                count_d          = major;
                // Step increments are precomputed so STEP is a single add.
                err_d            = (minor_s <<< 1) - major_s;
                inc_a_d          = minor_s <<< 1;
                inc_b_d          = (minor_s - major_s) <<< 1;
                state_d          = STEP;
            end
            STEP: begin
                if (pix_hs) begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        u_d     = u_q + 1'b1;
                        count_d = count_q - 1'b1;
                        if (!err_q[EW-1] && (err_q != '0)) begin
                            v_d   = v_q + 1'b1;
                            err_d = err_q + inc_b_q;
                        end else begin
                            err_d = err_q + inc_a_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            oct_q   <= '0;
            u_q     <= '0;
            v_q     <= '0;
            count_q <= '0;
            err_q   <= '0;
            inc_a_q <= '0;
            inc_b_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            oct_q   <= oct_d;
            u_q     <= u_d;
            v_q     <= v_d;
            count_q <= count_d;
            err_q   <= err_d;
            inc_a_q <= inc_a_d;
            inc_b_q <= inc_b_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign pix_valid   = (state_q == STEP);
    assign pix_last    = pix_valid && (count_q == '0);
    assign octant      = oct_q;

    octant_swapback #(
        .XW (XW),
        .YW (YW),
        .CW (CW)
    ) u_swapback (
        .u      (u_q),
        .v      (v_q),
        .octant (oct_q),
        .x0     (x0_q),
        .y0     (y0_q),
        .pix_x  (pix_x),
        .pix_y  (pix_y)
    );
endmodule

// File: tb/tb_line_octant_stepper.sv
// Directed and randomized line requests checked against a rounding-based line model.
module tb_line_octant_stepper;
    import rast_pkg::*;

    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;
    logic [2:0]    octant;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    line_octant_stepper #(.XW(XW), .YW(YW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_last    (pix_last),
        .octant      (octant),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ideal line: minor offset is i*minor/major rounded to nearest, ties rounded down.
    task automatic model_pix(input int ax0, input int ay0, input int ax1, input int ay1,
                             input int k, output int px, output int py);
        int adx, ady, sx, sy, mj, mn, v;
        adx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
        sx  = (ax1 < ax0) ? -1 : 1;
        sy  = (ay1 < ay0) ? -1 : 1;
        if (ady > adx) begin mj = ady; mn = adx; end
        else begin mj = adx; mn = ady; end
        v = (mj == 0) ? 0 : (2 * k * mn + mj - 1) / (2 * mj);
        if (ady > adx) begin
            py = ay0 + sy * k;
            px = ax0 + sx * v;
        end else begin
            px = ax0 + sx * k;
            py = ay0 + sy * v;
        end
    endtask

    function automatic bit pat_rdy(input int j);
        case (j)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // rmode: 0 = always ready, 1 = fixed stall pattern, 2 = random ready
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int rmode);
        int adx, ady, mj, k, cyc, budget, px, py, ex_oct;
        bit rdy;
        adx    = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        ady    = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
        mj     = (ady > adx) ? ady : adx;
        ex_oct = ((ay1 < ay0) ? 4 : 0) + ((ax1 < ax0) ? 2 : 0) + ((ady > adx) ? 1 : 0);

        chk("idle_start_ready", start_ready, 1);
        start_valid = 1'b1;
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("setup_pix_valid", pix_valid, 0);
        chk("setup_start_ready", start_ready, 0);
        chk("setup_busy", busy, 1);
        @(negedge clk);
        chk("first_pix_latency", pix_valid, 1);
        chk("octant", octant, ex_oct);

        k = 0; cyc = 0; budget = 4 * (mj + 1) + 16;
        while (k <= mj && cyc < budget) begin
            model_pix(ax0, ay0, ax1, ay1, k, px, py);
            chk("pix_valid", pix_valid, 1);
            chk("pix_x", pix_x, px);
            chk("pix_y", pix_y, py);
            chk("pix_last", pix_last, (k == mj));
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat_rdy(cyc);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            pix_ready = rdy;
            if (rmode != 0) begin
                start_valid = $urandom_range(0, 1) != 0;
                x0 = XW'($urandom_range(0, 639)); y0 = YW'($urandom_range(0, 479));
                x1 = XW'($urandom_range(0, 639)); y1 = YW'($urandom_range(0, 479));
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start_valid = 1'b0;
        chk("line_pixel_count", k, mj + 1);
        chk("end_start_ready", start_ready, 1);
        chk("end_pix_valid", pix_valid, 0);
        chk("end_busy", busy, 0);
        chk("octant_hold", octant, ex_oct);
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_octant", octant, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_line(0, 0, 3, 0, 0);
        run_line(5, 5, 3, 0, 0);
        run_line(0, 0, 3, 3, 0);
        run_line(7, 7, 7, 7, 0);
        run_line(0, 0, 3, 0, 1);
        run_line(639, 0, 0, 479, 0);

        // Abort a full-range line with reset partway through.
        pix_ready = 1'b1;
        start_valid = 1'b1;
        x0 = XW'(639); y0 = '0; x1 = '0; y1 = YW'(479);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_midline_valid", pix_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_pix_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_pix_last", pix_last, 0);
        chk("abort_octant", octant, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_pix_valid", pix_valid, 0);
            chk("post_abort_start_ready", start_ready, 1);
        end

        for (int i = 0; i < 10; i++) begin
            run_line($urandom_range(0, 639), $urandom_range(0, 479),
                     $urandom_range(0, 639), $urandom_range(0, 479), 2);
        end
        for (int i = 0; i < 20; i++) begin
            run_line($urandom_range(0, 12), $urandom_range(0, 12),
                     $urandom_range(0, 12), $urandom_range(0, 12), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
